master_port: RTL and testbench

- Master-side serial bus engine for the ADS serial bus.
- Accepts one parallel read or write request from a local device, requests the bus from the arbiter, and serialises the transaction LSB-first onto mwdata/mvalid:
  - first the 4-bit device address, consumed by the address decoder;
  - then the 12-bit memory address and, for writes, 8 data bits.
- For reads it deserialises slave data from mrdata.
- Handles ack timeout and split suspension/resumption.

---
 rtl/master_port.sv | 195 +++++++++++++++++++
 tb/tb_master_port.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// Master-side engine for the ADS serial bus: takes one parallel read/write request,
// wins the bus, shifts device address, memory address and write data out LSB-first,
// and collects serial read data, including split suspension and resumption.
//
// state  | meaning
// IDLE   | ready for a request; ddone/derr pulse here after completion
// REQ    | request held on mbreq, waiting for grant
// DADDR  | shifting the device address
// WACK   | waiting for the decoder ack, bounded by the timeout counter
// MADDR  | shifting the memory address
// WDATA  | shifting write data
// RDATA  | collecting read bits from the slave
// SPLIT  | slave split the transfer; bus released until regranted
module master_port #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DEVICE_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int ACK_TIMEOUT       = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derr,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  mwdata,
    output logic                  mvalid,
    output logic                  mmode,
    input  logic                  ack,
    input  logic                  mrdata,
    input  logic                  svalid,
    input  logic                  msplit
);

    localparam int MEM_AW = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
    localparam int CNT_W  = $clog2(MEM_AW + 1);
    localparam int RCNT_W = $clog2(DATA_WIDTH);
    localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  DEV_LAST  = CNT_W'(DEVICE_ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]  MEM_LAST  = CNT_W'(MEM_AW - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [RCNT_W-1:0] RD_LAST   = RCNT_W'(DATA_WIDTH - 1);
    localparam logic [TCNT_W-1:0] TO_LOAD   = TCNT_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DADDR = 3'd2;
    localparam logic [2:0] S_WACK  = 3'd3;
    localparam logic [2:0] S_MADDR = 3'd4;
    localparam logic [2:0] S_WDATA = 3'd5;
    localparam logic [2:0] S_RDATA = 3'd6;
    localparam logic [2:0] S_SPLIT = 3'd7;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mode_q;
    logic [MEM_AW-1:0]     tx_sh;
    logic [CNT_W-1:0]      cnt;
    logic [RCNT_W-1:0]     rcnt;
    logic [TCNT_W-1:0]     tcnt;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_nxt;
    logic [DATA_WIDTH-1:0] drdata_q;
    logic                  ddone_q;
    logic                  derr_q;

    assign dready = (state == S_IDLE);
    assign mbreq  = (state != S_IDLE) && (state != S_SPLIT);
    assign mvalid = (state == S_DADDR) || (state == S_MADDR) || (state == S_WDATA);
    assign mwdata = mvalid & tx_sh[0];
    assign mmode  = (state != S_IDLE) & mode_q;
    assign drdata = drdata_q;
    assign ddone  = ddone_q;
    assign derr   = derr_q;

    always_comb begin
        rx_nxt       = rx_sh;
        rx_nxt[rcnt] = mrdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            mode_q   <= 1'b0;
            tx_sh    <= '0;
            cnt      <= '0;
            rcnt     <= '0;
            tcnt     <= '0;
            rx_sh    <= '0;
            drdata_q <= '0;
            ddone_q  <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            ddone_q <= 1'b0;
            derr_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dvalid) begin
                        addr_q  <= daddr;
                        wdata_q <= dwdata;
                        mode_q  <= dmode;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mbgrant) begin
                        cnt   <= '0;
                        tx_sh <= {{(MEM_AW - DEVICE_ADDR_WIDTH){1'b0}},
                                  addr_q[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH]};
                        state <= S_DADDR;
                    end
                end
                S_DADDR: begin
                    tx_sh <= tx_sh >> 1;
                    if (cnt == DEV_LAST) begin
                        tcnt  <= TO_LOAD;
                        state <= S_WACK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WACK: begin
                    // ack wins over an expiring timeout in the same cycle
                    if (ack) begin
                        cnt   <= '0;
                        tx_sh <= addr_q[MEM_AW-1:0];
                        state <= S_MADDR;
                    end else if (tcnt == '0) begin
                        ddone_q <= 1'b1;
                        derr_q  <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tcnt <= tcnt - TCNT_W'(1);
                    end
                end
                S_MADDR: begin
                    tx_sh <= tx_sh >> 1;
                    if (cnt == MEM_LAST) begin
                        cnt <= '0;
                        if (mode_q) begin
                            tx_sh <= {{(MEM_AW - DATA_WIDTH){1'b0}}, wdata_q};
                            state <= S_WDATA;
                        end else begin
                            rcnt  <= '0;
                            rx_sh <= '0;
                            state <= S_RDATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WDATA: begin
                    tx_sh <= tx_sh >> 1;
                    if (cnt == DATA_LAST) begin
                        ddone_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RDATA: begin
                    if (svalid) begin
                        rx_sh <= rx_nxt;
                        if (rcnt == RD_LAST) begin
                            drdata_q <= rx_nxt;
                            ddone_q  <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            rcnt <= rcnt + RCNT_W'(1);
                            if (msplit) state <= S_SPLIT;
                        end
                    end else if (msplit) begin
                        state <= S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    // resume where we left off; the decoder restores the slave itself
                    if (mbgrant) state <= S_RDATA;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: stimulus queues the expected serial bits and
// completions, a negedge monitor pops and compares whenever the DUT presents them.
module tb_master_port;

    typedef struct packed {
        logic       err;
        logic       chk_rd;
        logic [7:0] rd;
    } done_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dvalid;
    logic        dready;
    logic        dmode;
    logic [15:0] daddr;
    logic [7:0]  dwdata;
    logic [7:0]  drdata;
    logic        ddone;
    logic        derr;
    logic        mbreq;
    logic        mbgrant;
    logic        mwdata;
    logic        mvalid;
    logic        mmode;
    logic        ack;
    logic        mrdata;
    logic        svalid;
    logic        msplit;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  exp_bits[$];
    done_t       exp_done[$];
    logic [1:0]  e_bit;
    done_t       e_done;
    logic [7:0]  rd_val;
    int          cyc;

    master_port dut (
        .clk    (clk),
        .rstn   (rstn),
        .dvalid (dvalid),
        .dready (dready),
        .dmode  (dmode),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .ddone  (ddone),
        .derr   (derr),
        .mbreq  (mbreq),
        .mbgrant(mbgrant),
        .mwdata (mwdata),
        .mvalid (mvalid),
        .mmode  (mmode),
        .ack    (ack),
        .mrdata (mrdata),
        .svalid (svalid),
        .msplit (msplit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [15:0] v, input int n, input logic m);
        for (int i = 0; i < n; i++) exp_bits.push_back({m, v[i]});
    endtask

    task automatic do_req(input logic m, input logic [15:0] a, input logic [7:0] w);
        dvalid = 1'b1;
        dmode  = m;
        daddr  = a;
        dwdata = w;
        @(negedge clk);
        dvalid = 1'b0;
    endtask

    task automatic wait_bits(input string name, input int n);
        int seen = 0;
        for (int c = 0; c < 200 && seen < n; c++) begin
            @(negedge clk);
            if (mvalid === 1'b1) seen++;
        end
        chk(name, seen, n);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (ddone !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(name, ddone, 1);
    endtask

    // monitor: every presented bit and completion must match the head of its queue
    always @(negedge clk) begin
        if (mvalid === 1'b1) begin
            chk("bit_expected", exp_bits.size() > 0, 1);
            if (exp_bits.size() > 0) begin
                e_bit = exp_bits.pop_front();
                chk("mwdata", mwdata, e_bit[0]);
                chk("mmode", mmode, e_bit[1]);
            end
        end
        if (ddone === 1'b1) begin
            chk("done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) begin
                e_done = exp_done.pop_front();
                chk("derr", derr, e_done.err);
                if (e_done.chk_rd) chk("drdata", drdata, e_done.rd);
            end
        end
        if (derr === 1'b1) chk("derr_with_ddone", ddone, 1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; dvalid = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
        mbgrant = 1'b1; ack = 1'b1; mrdata = 1'b0; svalid = 1'b0; msplit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dready", dready, 1);
        chk("rst_mbreq", mbreq, 0);
        chk("rst_mvalid", mvalid, 0);
        chk("rst_mwdata", mwdata, 0);
        chk("rst_mmode", mmode, 0);
        chk("rst_ddone", ddone, 0);
        chk("rst_derr", derr, 0);
        chk("rst_drdata", drdata, 0);
        rstn = 1'b1;
        @(negedge clk);

        // write 0x1A53 <- 0xC6, immediate grant and ack
        push_bits(16'h1, 4, 1'b1);
        push_bits(16'hA53, 12, 1'b1);
        push_bits(16'hC6, 8, 1'b1);
        exp_done.push_back({1'b0, 1'b0, 8'h00});
        do_req(1'b1, 16'h1A53, 8'hC6);
        chk("wr_dready_low", dready, 0);
        chk("wr_mbreq_req", mbreq, 1);
        wait_done("wr_done");
        chk("wr_mbreq_off", mbreq, 0);
        chk("wr_dready_done", dready, 1);
        @(negedge clk);
        chk("wr_ddone_pulse", ddone, 0);

        // read 0x2004, slave returns 0x5B
        rd_val = 8'h5B;
        push_bits(16'h2, 4, 1'b0);
        push_bits(16'h004, 12, 1'b0);
        exp_done.push_back({1'b0, 1'b1, 8'h5B});
        do_req(1'b0, 16'h2004, 8'h00);
        wait_bits("rd_bits", 16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rd_mbreq", mbreq, 1);
                chk("rd_mvalid", mvalid, 0);
                chk("rd_mmode", mmode, 0);
            end
            svalid = 1'b1;
            mrdata = rd_val[i];
        end
        @(negedge clk);
        svalid = 1'b0; mrdata = 1'b0;
        wait_done("rd_done");
        @(negedge clk);

        // ack timeout on device 3
        ack = 1'b0;
        push_bits(16'h3, 4, 1'b0);
        exp_done.push_back({1'b1, 1'b0, 8'h00});
        do_req(1'b0, 16'h3000, 8'h00);
        wait_bits("to_bits", 4);
        cyc = 0;
        while (ddone !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_wack_cycles", cyc, 5);
        chk("to_mbreq", mbreq, 0);
        @(negedge clk);
        ack = 1'b1;
        repeat (3) @(negedge clk);

        // split after 3 read bits, regrant after 10 low cycles
        rd_val = 8'hA7;
        push_bits(16'h2, 4, 1'b0);
        push_bits(16'h010, 12, 1'b0);
        exp_done.push_back({1'b0, 1'b1, 8'hA7});
        do_req(1'b0, 16'h2010, 8'h00);
        wait_bits("sp_bits", 16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            svalid = 1'b1;
            mrdata = rd_val[i];
        end
        @(negedge clk);
        svalid = 1'b0; msplit = 1'b1; mbgrant = 1'b0;
        @(negedge clk);
        msplit = 1'b0;
        chk("sp_mbreq_low", mbreq, 0);
        chk("sp_mvalid_low", mvalid, 0);
        repeat (8) @(negedge clk);
        chk("sp_mbreq_still_low", mbreq, 0);
        @(negedge clk);
        mbgrant = 1'b1;
        for (int i = 3; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) chk("sp_resume_mbreq", mbreq, 1);
            svalid = 1'b1;
            mrdata = rd_val[i];
        end
        @(negedge clk);
        svalid = 1'b0; mrdata = 1'b0;
        wait_done("sp_done");
        @(negedge clk);

        // reset for one cycle at memory-address bit 5
        push_bits(16'h1, 4, 1'b1);
        push_bits(16'h234, 6, 1'b1);
        do_req(1'b1, 16'h1234, 8'h55);
        wait_bits("rs_bits", 10);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rs_mvalid", mvalid, 0);
        chk("rs_mbreq", mbreq, 0);
        chk("rs_dready", dready, 1);
        chk("rs_ddone", ddone, 0);
        chk("rs_drdata", drdata, 0);
        repeat (4) @(negedge clk);

        // back-to-back writes, second dvalid held through the first ddone
        push_bits(16'h1, 4, 1'b1);
        push_bits(16'h001, 12, 1'b1);
        push_bits(16'h3C, 8, 1'b1);
        exp_done.push_back({1'b0, 1'b0, 8'h00});
        push_bits(16'h2, 4, 1'b1);
        push_bits(16'hF0F, 12, 1'b1);
        push_bits(16'h81, 8, 1'b1);
        exp_done.push_back({1'b0, 1'b0, 8'h00});
        dvalid = 1'b1; dmode = 1'b1; daddr = 16'h1001; dwdata = 8'h3C;
        @(negedge clk);
        daddr = 16'h2F0F; dwdata = 8'h81;
        wait_done("b2b_done1");
        chk("b2b_dready", dready, 1);
        @(negedge clk);
        chk("b2b_mbreq_again", mbreq, 1);
        chk("b2b_accepted", dready, 0);
        dvalid = 1'b0;
        wait_done("b2b_done2");
        repeat (3) @(negedge clk);

        chk("bits_left", exp_bits.size(), 0);
        chk("done_left", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
